// File: rtl/lut_layer_pkg.sv
// Shared types and helpers for the LUT neuron layer and its wrappers.
package lut_layer_pkg;

  localparam int unsigned FANIN_DEF = 6;
  localparam int unsigned DEPTH     = 2 ** FANIN_DEF;

  // Index width that never collapses to zero for single-element ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic int unsigned depth_of(input int unsigned fanin);
    return 32'd1 << fanin;
  endfunction

  typedef struct packed {
    logic s1_valid;
    logic s2_valid;
  } hs_state_t;

endpackage

// File: rtl/lut_neuron_tbl.sv
// One neuron truth table: synchronous write port, combinational lookup.
// LUT_NEURON_READBACK_EN adds a second combinational read port for config readback.
module lut_neuron_tbl
  import lut_layer_pkg::*;
#(
  parameter int unsigned FANIN = 6,
  parameter int unsigned OUT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [FANIN-1:0] waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic [FANIN-1:0] raddr,
  output logic [OUT_W-1:0] rdata
`ifdef LUT_NEURON_READBACK_EN
  ,
  input  logic [FANIN-1:0] rb_addr,
  output logic [OUT_W-1:0] rb_data
`endif
);

  localparam int unsigned TBL_DEPTH = depth_of(FANIN);

  (* ram_style = "distributed" *) logic [OUT_W-1:0] tbl [TBL_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TBL_DEPTH; i++) tbl[i] <= '0;
    end else if (we) begin
      tbl[waddr] <= wdata;
    end
  end

  assign rdata = tbl[raddr];

`ifdef LUT_NEURON_READBACK_EN
  assign rb_data = tbl[rb_addr];
`endif

endmodule

// File: rtl/lut_neuron_layer_pipe.sv
// Runtime-programmable LogicNets layer: N truth-table neurons behind a 2-stage
// valid/ready pipeline. Optional config readback via LUT_NEURON_READBACK_EN.
module lut_neuron_layer_pipe
  import lut_layer_pkg::*;
#(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned FANIN     = 6,
  parameter int unsigned OUT_W     = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_NEURONS*FANIN-1:0]       in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_NEURONS*OUT_W-1:0]       out_data,
  input  logic                             cfg_we,
  input  logic [clog2_min1(N_NEURONS)-1:0] cfg_neuron,
  input  logic [FANIN-1:0]                 cfg_addr,
  input  logic [OUT_W-1:0]                 cfg_wdata,
  output logic [CNT_W-1:0]                 tok_count
`ifdef LUT_NEURON_READBACK_EN
  ,
  input  logic                             cfg_re,
  output logic [OUT_W-1:0]                 cfg_rdata
`endif
);

  localparam int unsigned NW = clog2_min1(N_NEURONS);

  hs_state_t                      hs;
  logic [N_NEURONS*FANIN-1:0]     s1_addr;
  logic [N_NEURONS*OUT_W-1:0]     lookup;
  logic                           s1_adv;
  logic                           s2_adv;
  logic                           accept;

  assign s2_adv    = !hs.s2_valid || out_ready;
  assign s1_adv    = s2_adv || !hs.s1_valid;
  assign in_ready  = rst_n && s1_adv && !cfg_we;
  assign accept    = in_valid && in_ready;
  assign out_valid = hs.s2_valid;

`ifdef LUT_NEURON_READBACK_EN
  logic [OUT_W-1:0] rb_data [N_NEURONS];
`endif

  // Out-of-range cfg_neuron matches no table, so the write is dropped.
  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    logic we_k;
    assign we_k = cfg_we && (cfg_neuron == NW'(k));

    lut_neuron_tbl #(
      .FANIN (FANIN),
      .OUT_W (OUT_W)
    ) u_tbl (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (we_k),
      .waddr   (cfg_addr),
      .wdata   (cfg_wdata),
      .raddr   (s1_addr[k*FANIN +: FANIN]),
      .rdata   (lookup[k*OUT_W +: OUT_W])
`ifdef LUT_NEURON_READBACK_EN
      ,
      .rb_addr (cfg_addr),
      .rb_data (rb_data[k])
`endif
    );
  end

  // Lookup reads the table before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs        <= '0;
      s1_addr   <= '0;
      out_data  <= '0;
      tok_count <= '0;
    end else begin
      if (s1_adv) begin
        hs.s1_valid <= accept;
        if (accept) s1_addr <= in_data;
      end
      if (s2_adv) begin
        hs.s2_valid <= hs.s1_valid;
        if (hs.s1_valid) out_data <= lookup;
      end
      if (out_valid && out_ready && (tok_count != {CNT_W{1'b1}}))
        tok_count <= tok_count + CNT_W'(1);
    end
  end

`ifdef LUT_NEURON_READBACK_EN
  logic [OUT_W-1:0] rb_sel;

  always_comb begin
    rb_sel = '0;
    for (int unsigned k = 0; k < N_NEURONS; k++)
      if (cfg_neuron == NW'(k)) rb_sel = rb_data[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      cfg_rdata <= '0;
    else if (cfg_re) cfg_rdata <= rb_sel;
  end
`endif

endmodule

// File: tb/tb_lut_neuron_layer_pipe.sv
// Directed self-checking bench for lut_neuron_layer_pipe (4 neurons, FANIN 6, OUT_W 1, CNT_W 4).
module tb_lut_neuron_layer_pipe;

  localparam int unsigned N = 4;
  localparam int unsigned F = 6;
  localparam int unsigned W = 1;
  localparam int unsigned C = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*F-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic           cfg_we;
  logic [1:0]     cfg_neuron;
  logic [F-1:0]   cfg_addr;
  logic [W-1:0]   cfg_wdata;
  logic [C-1:0]   tok_count;
`ifdef LUT_NEURON_READBACK_EN
  logic           cfg_re;
  logic [W-1:0]   cfg_rdata;
`endif

  int tests = 0;
  int fails = 0;
  int exp_tok = 0;

  lut_neuron_layer_pipe #(
    .N_NEURONS (N),
    .FANIN     (F),
    .OUT_W     (W),
    .CNT_W     (C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .tok_count  (tok_count)
`ifdef LUT_NEURON_READBACK_EN
    ,
    .cfg_re     (cfg_re),
    .cfg_rdata  (cfg_rdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Neuron 0 function: ~a[3] with two overrides; entry 0x08 therefore reads 0.
  function automatic logic f0(input logic [5:0] a);
    if (a == 6'h3C) return 1'b1;
    if (a == 6'h03) return 1'b0;
    return ~a[3];
  endfunction

  function automatic logic [3:0] exp_word(input logic [23:0] d);
    return {3'b111, f0(d[5:0])};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add_tok(input int n);
    exp_tok = (exp_tok + n > 15) ? 15 : exp_tok + n;
  endtask

  task automatic program_tables;
    for (int n = 0; n < 4; n++) begin
      for (int a = 0; a < 64; a++) begin
        cfg_we     = 1'b1;
        cfg_neuron = 2'(n);
        cfg_addr   = 6'(a);
        cfg_wdata  = (n == 0) ? f0(6'(a)) : 1'b1;
        tick();
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_data !== 4'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
    tests++; if (tok_count !== 4'h0) begin fails++; $display("FAIL reset_tok_count got %0d want 0", tok_count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_lookup;
    logic [5:0] addrs [4];
    logic [3:0] expv  [4];
    addrs = '{6'h08, 6'h3C, 6'h03, 6'h00};
    expv  = '{4'b1110, 4'b1111, 4'b1110, 4'b1111};
    program_tables();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = {6'h15, 6'h2A, 6'h3F, addrs[i]};
      tick();
      in_valid = 1'b0;
      tick();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL lookup_valid[%0d] got %b want 1", i, out_valid); end
      tests++; if (out_data !== expv[i]) begin fails++; $display("FAIL lookup_data[%0d] got %h want %h", i, out_data, expv[i]); end
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lookup_drain[%0d] got %b want 0", i, out_valid); end
    end
    add_tok(4);
  endtask

  task automatic test_stream;
    logic [23:0] w [8];
    w = '{24'h000000, 24'h041008, 24'hFFF03C, 24'h123403, 24'h0AB004, 24'h555510, 24'h3C0018, 24'h00002F};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w[0];
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      if (cyc < 8) in_data = w[cyc];
      else         in_valid = 1'b0;
      if (cyc < 8) begin
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d] got %b want 1", cyc, in_ready); end
      end
      if (cyc >= 2) begin
        tests++; if (out_valid !== 1'b1 || out_data !== exp_word(w[cyc-2])) begin
          fails++; $display("FAIL stream_word[%0d] got v=%b d=%h want v=1 d=%h", cyc-2, out_valid, out_data, exp_word(w[cyc-2]));
        end
      end
    end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_end_valid got %b want 0", out_valid); end
    add_tok(8);
    tests++; if (tok_count !== 4'(exp_tok)) begin fails++; $display("FAIL stream_tok got %0d want %0d", tok_count, exp_tok); end
  endtask

  task automatic test_backpressure;
    logic [23:0] w [8];
    logic [3:0]  q [$];
    logic [3:0]  held;
    logic [3:0]  front;
    logic        hold_v;
    int          sent;
    int          recv;
    int          cyc;
    for (int i = 0; i < 8; i++) w[i] = {6'(i * 7), 6'(i * 3), 6'(i * 5), 6'(i * 9 + 1)};
    hold_v = 1'b0;
    held   = '0;
    sent   = 0;
    recv   = 0;
    cyc    = 0;
    while (recv < 8 && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc < 8);
      in_valid  = (sent < 8);
      if (sent < 8) in_data = w[sent];
      #1;
      if (hold_v) begin
        tests++; if (out_valid !== 1'b1 || out_data !== held) begin
          fails++; $display("FAIL bp_hold[%0d] got v=%b d=%h want v=1 d=%h", cyc, out_valid, out_data, held);
        end
      end
      if (cyc >= 4 && cyc < 8) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b want 0", cyc, in_ready); end
      end
      if (in_valid && in_ready) begin
        q.push_back(exp_word(w[sent]));
        sent++;
      end
      hold_v = out_valid && !out_ready;
      held   = out_data;
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL bp_extra got d=%h want no word", out_data);
        end else begin
          front = q.pop_front();
          if (out_data !== front) begin fails++; $display("FAIL bp_word[%0d] got %h want %h", recv, out_data, front); end
        end
        recv++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++; if (recv != 8 || sent != 8) begin fails++; $display("FAIL bp_count got recv=%0d sent=%0d want 8/8", recv, sent); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_dup got out_valid=%b want 0", out_valid); end
    add_tok(8);
  endtask

  task automatic test_collision;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {18'h0, 6'h08};
    tick();
    in_valid   = 1'b0;
    cfg_we     = 1'b1;
    cfg_neuron = 2'd0;
    cfg_addr   = 6'h08;
    cfg_wdata  = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL coll_in_ready got %b want 0", in_ready); end
    tick();
    cfg_we = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 4'b1110) begin
      fails++; $display("FAIL coll_old got v=%b d=%h want v=1 d=e", out_valid, out_data);
    end
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 4'b1111) begin
      fails++; $display("FAIL coll_new got v=%b d=%h want v=1 d=f", out_valid, out_data);
    end
    tick();
    add_tok(2);
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {6'h01, 6'h02, 6'h03, 6'h3C};
    tick();
    in_data = {6'h3F, 6'h3F, 6'h3F, 6'h00};
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_inflight got %b want 1", out_valid); end
    rst_n = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    tests++; if (tok_count !== 4'h0) begin fails++; $display("FAIL mid_rst_tok got %0d want 0", tok_count); end
    tests++; if (out_data !== 4'h0) begin fails++; $display("FAIL mid_rst_data got %h want 0", out_data); end
    rst_n   = 1'b1;
    exp_tok = 0;
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_no_leak got %b want 0", out_valid); end
    in_valid = 1'b1;
    in_data  = {6'h3F, 6'h3F, 6'h3F, 6'h3C};
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 4'h0) begin
      fails++; $display("FAIL mid_cleared_tbl got v=%b d=%h want v=1 d=0", out_valid, out_data);
    end
    tick();
    add_tok(1);
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 23; i++) begin
      in_data = {6'(i), 6'(i + 1), 6'(i + 2), 6'(i + 3)};
      tick();
      if (i == 19) in_valid = 1'b0;
      if (i >= 1 && i <= 20) begin
        tests++; if (out_valid !== 1'b1 || out_data !== 4'h0) begin
          fails++; $display("FAIL sat_word[%0d] got v=%b d=%h want v=1 d=0", i, out_valid, out_data);
        end
      end
    end
    add_tok(20);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sat_drain got %b want 0", out_valid); end
    tests++; if (tok_count !== 4'(exp_tok)) begin fails++; $display("FAIL sat_tok got %0d want %0d", tok_count, exp_tok); end
    tests++; if (tok_count !== 4'd15) begin fails++; $display("FAIL sat_max got %0d want 15", tok_count); end
  endtask

`ifdef LUT_NEURON_READBACK_EN
  task automatic test_readback;
    cfg_re     = 1'b1;
    cfg_neuron = 2'd0;
    cfg_addr   = 6'h08;
    tick();
    cfg_re = 1'b0;
    tests++; if (cfg_rdata !== 1'b1) begin fails++; $display("FAIL rb_read got %b want 1", cfg_rdata); end
    cfg_addr = 6'h03;
    tick();
    tests++; if (cfg_rdata !== 1'b1) begin fails++; $display("FAIL rb_hold got %b want 1", cfg_rdata); end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    cfg_we     = 1'b0;
    cfg_neuron = '0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
`ifdef LUT_NEURON_READBACK_EN
    cfg_re     = 1'b0;
`endif
    test_reset();
    test_lookup();
    test_stream();
    test_backpressure();
    test_collision();
`ifdef LUT_NEURON_READBACK_EN
    test_readback();
`endif
    test_reset_midstream();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
